// File: rtl/mesh_inject_arbiter.sv
// Injection arbiter: N_REQ local requesters, each with its own FIFO, share one
// mesh router input port under round-robin arbitration with a stall watchdog.
module mesh_inject_arbiter #(
   parameter int N_REQ      = 4,
   parameter int PCKG_SZ    = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*PCKG_SZ-1:0]   req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       port_pndng,
   output logic [PCKG_SZ-1:0]         port_data,
   input  logic                       port_pop,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic [15:0]                pkt_cnt,
   output logic                       stall_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(N_REQ);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              r_state;
   logic [PCKG_SZ-1:0]  r_mem    [N_REQ][FIFO_DEPTH];
   logic [AW:0]         r_wr_ptr [N_REQ];
   logic [AW:0]         r_rd_ptr [N_REQ];
   logic [GW-1:0]       r_last_grant;
   logic [GW-1:0]       r_grant_id;
   logic [PCKG_SZ-1:0]  r_port_data;
   logic [15:0]         r_pkt_cnt;
   logic [WW-1:0]       r_wait;
   logic                r_stall;

   logic [N_REQ-1:0]    w_empty;
   logic [N_REQ-1:0]    w_full;
   logic [N_REQ-1:0]    w_push;
   logic [N_REQ-1:0]    w_pop;
   logic                w_found;
   logic [GW-1:0]       w_winner;
   logic                w_load;
   logic [PCKG_SZ-1:0]  w_head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
         w_full[i]  = (r_wr_ptr[i][AW] != r_rd_ptr[i][AW]) &&
                      (r_wr_ptr[i][AW-1:0] == r_rd_ptr[i][AW-1:0]);
      end
   end

   assign req_ready = ~w_full & {N_REQ{~reset}};
   assign w_push    = req_valid & req_ready;

   // Round-robin search starting just after the previous winner, using occupancy
   // before this edge's writes.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_found && !w_empty[GW'((int'(r_last_grant) + k) % N_REQ)]) begin
            w_found  = 1'b1;
            w_winner = GW'((int'(r_last_grant) + k) % N_REQ);
         end
      end
   end

   assign w_load = w_found && ((r_state == IDLE) || port_pop);
   assign w_head = r_mem[w_winner][r_rd_ptr[w_winner][AW-1:0]];

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         w_pop[i] = w_load && (w_winner == GW'(i));
   end

   // NOTE: packet storage has no reset; the pointers alone define validity, so
   // clearing them empties every FIFO without touching the data array.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++)
         if (w_push[i])
            r_mem[i][r_wr_ptr[i][AW-1:0]] <= req_data[i*PCKG_SZ +: PCKG_SZ];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + (AW+1)'(1);
            if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= GW'(N_REQ - 1);
         r_grant_id   <= '0;
         r_port_data  <= '0;
         r_pkt_cnt    <= '0;
         r_wait       <= '0;
         r_stall      <= 1'b0;
      end else begin
         if (w_load) begin
            r_state      <= BUSY;
            r_port_data  <= w_head;
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_wait       <= '0;
         end
         case (r_state)
            IDLE: ;
            BUSY: begin
               if (port_pop) begin
                  r_pkt_cnt <= r_pkt_cnt + 16'd1;
                  if (!w_found) begin
                     r_state <= IDLE;
                     r_wait  <= '0;
                  end
               end else begin
                  // Saturate the wait counter; the flag sets on the edge it reaches TIMEOUT.
                  if (r_wait != WW'(TIMEOUT)) r_wait <= r_wait + WW'(1);
                  if (r_wait >= WW'(TIMEOUT - 1)) r_stall <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign port_pndng = (r_state == BUSY);
   assign port_data  = r_port_data;
   assign grant_id   = r_grant_id;
   assign pkt_cnt    = r_pkt_cnt;
   assign stall_err  = r_stall;

endmodule

// File: tb/tb_mesh_inject_arbiter.sv
// Directed bench for mesh_inject_arbiter: reset, spurious pop, single packet,
// backpressure, timeout, reset mid-BUSY and round-robin back-to-back.
module tb_mesh_inject_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req_valid;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic          port_pndng;
   logic [31:0]   port_data;
   logic          port_pop;
   logic [1:0]    grant_id;
   logic [15:0]   pkt_cnt;
   logic          stall_err;

   int checks   = 0;
   int failures = 0;

   mesh_inject_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .port_pndng (port_pndng),
      .port_data  (port_data),
      .port_pop   (port_pop),
      .grant_id   (grant_id),
      .pkt_cnt    (pkt_cnt),
      .stall_err  (stall_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      port_pop  = 1'b0;
      step();
      step();
      check("rst_ready_low", 32'(req_ready), 32'h0);

      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'hF);
      check("post_rst_pndng", 32'(port_pndng), 32'h0);
      check("post_rst_cnt", 32'(pkt_cnt), 32'h0);
      check("post_rst_grant", 32'(grant_id), 32'h0);
      check("post_rst_stall", 32'(stall_err), 32'h0);
      check("post_rst_data", port_data, 32'h0);

      // Pop while IDLE does nothing.
      port_pop = 1'b1;
      step();
      check("spurious_cnt", 32'(pkt_cnt), 32'h0);
      check("spurious_pndng", 32'(port_pndng), 32'h0);
      port_pop = 1'b0;

      // Single packet on requester 2.
      req_valid = 4'b0100;
      req_data[64 +: 32] = 32'hA5A5_0001;
      step();
      check("single_write_edge_pndng", 32'(port_pndng), 32'h0);
      req_valid = '0;
      step();
      check("single_pndng", 32'(port_pndng), 32'h1);
      check("single_data", port_data, 32'hA5A5_0001);
      check("single_grant", 32'(grant_id), 32'h2);
      port_pop = 1'b1;
      step();
      port_pop = 1'b0;
      check("single_cnt", 32'(pkt_cnt), 32'h1);
      check("single_idle", 32'(port_pndng), 32'h0);

      // Backpressure on requester 1: first packet is loaded at the second edge,
      // so five writes leave four buffered and the FIFO full.
      req_valid = 4'b0010;
      for (int p = 1; p <= 5; p++) begin
         req_data[32 +: 32] = 32'hB000_0000 + 32'(p);
         step();
      end
      check("bp_ready", 32'(req_ready), 32'hD);
      req_data[32 +: 32] = 32'hB000_0006;
      step();
      req_valid = '0;
      check("bp_ready_hold", 32'(req_ready), 32'hD);
      check("bp_data_stable", port_data, 32'hB000_0001);
      check("bp_grant", 32'(grant_id), 32'h1);

      // Wait count is 4 here; 59 more idle edges reach 63, one more reaches 64.
      repeat (59) step();
      check("to_before", 32'(stall_err), 32'h0);
      step();
      check("to_set", 32'(stall_err), 32'h1);
      check("to_pndng", 32'(port_pndng), 32'h1);
      check("to_data", port_data, 32'hB000_0001);
      repeat (5) step();
      check("to_sticky", 32'(stall_err), 32'h1);

      port_pop = 1'b1;
      step();
      port_pop = 1'b0;
      check("to_pop_cnt", 32'(pkt_cnt), 32'h2);
      check("to_pop_data", port_data, 32'hB000_0002);
      check("to_pop_grant", 32'(grant_id), 32'h1);
      check("to_pop_stall", 32'(stall_err), 32'h1);
      check("to_pop_pndng", 32'(port_pndng), 32'h1);

      // Reset while BUSY with P3..P5 still buffered.
      reset = 1'b1;
      step();
      check("mid_rst_pndng", 32'(port_pndng), 32'h0);
      check("mid_rst_cnt", 32'(pkt_cnt), 32'h0);
      check("mid_rst_stall", 32'(stall_err), 32'h0);
      check("mid_rst_ready_low", 32'(req_ready), 32'h0);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'hF);
      step();
      check("mid_rst_discard", 32'(port_pndng), 32'h0);

      // Round-robin: two packets per requester, continuous pop.
      req_valid = 4'hF;
      for (int r = 0; r < 4; r++) req_data[r*32 +: 32] = 32'hD000_0000 | 32'(r << 4);
      step();
      for (int r = 0; r < 4; r++) req_data[r*32 +: 32] = 32'hD000_0001 | 32'(r << 4);
      step();
      req_valid = '0;
      port_pop  = 1'b1;
      check("rr0_pndng", 32'(port_pndng), 32'h1);
      check("rr0_grant", 32'(grant_id), 32'h0);
      check("rr0_data", port_data, 32'hD000_0000);
      for (int k = 1; k < 8; k++) begin
         step();
         check($sformatf("rr%0d_pndng", k), 32'(port_pndng), 32'h1);
         check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(k % 4));
         check($sformatf("rr%0d_data", k), port_data, 32'hD000_0000 | 32'((k % 4) << 4) | 32'(k / 4));
      end
      step();
      port_pop = 1'b0;
      check("rr_cnt", 32'(pkt_cnt), 32'h8);
      check("rr_idle", 32'(port_pndng), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mesh_inject_arbiter.md
MESH_INJECT_ARBITER -- requirements
Module: mesh_inject_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of local requesters sharing one mesh router input port.
REQ-002 Parameter PCKG_SZ, default 32: packet width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: per-requester buffer depth in entries, power of two and at least 2.
REQ-004 Parameter TIMEOUT, default 64: number of BUSY cycles without port_pop before a stall is flagged.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  N_REQ  per-requester packet offer.
REQ-008 req_data  input  N_REQ*PCKG_SZ  per-requester packet; requester i occupies bits [i*PCKG_SZ +: PCKG_SZ].
REQ-009 req_ready  output  N_REQ  per-requester FIFO not full.
REQ-010 port_pndng  output  1  packet pending toward the router input (router pndng_i_in).
REQ-011 port_data  output  PCKG_SZ  packet toward the router input (router data_out_i_in).
REQ-012 port_pop  input  1  router acknowledge; consumes the presented packet.
REQ-013 grant_id  output  $clog2(N_REQ)  requester whose packet is currently presented.
REQ-014 pkt_cnt  output  16  count of packets accepted by the router.
REQ-015 stall_err  output  1  sticky flag: router failed to acknowledge within TIMEOUT cycles.

Function
REQ-016 Each requester SHALL own one FIFO of FIFO_DEPTH entries.
REQ-017 req_ready[i] SHALL equal !full[i] and SHALL be 0 while reset is high.
REQ-018 A write into FIFO i SHALL occur at the posedge where req_valid[i] and req_ready[i] are both 1.
REQ-019 The FSM SHALL have two states: IDLE (port_pndng=0) and BUSY (port_pndng=1).
REQ-020 Winner selection SHALL be round-robin over FIFOs that are non-empty at the current edge (pre-write occupancy), searching last_grant+1, last_grant+2, ... modulo N_REQ.
REQ-021 Load, IDLE state: at a posedge with any FIFO non-empty, the block SHALL pop the winner's head into port_data, set grant_id and last_grant to the winner, clear the wait counter, and go to BUSY.
REQ-022 While BUSY and port_pop=0, port_data and grant_id SHALL be held stable.
REQ-023 Acknowledge, BUSY state: at a posedge with port_pop=1, pkt_cnt SHALL increment, wrapping at 16 bits.
REQ-024 At that same edge, if any FIFO is non-empty the block SHALL load the next winner per REQ-021 and remain BUSY (back-to-back, no idle cycle); otherwise it SHALL go to IDLE.
REQ-025 Latency: a packet written at edge k into an empty FIFO while IDLE SHALL be presented with port_pndng=1 after edge k+1.
REQ-026 A simultaneous write and pop on the same FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 port_pop while IDLE SHALL be ignored: no count change and no state change.
REQ-029 While BUSY, the wait counter SHALL increment every cycle without port_pop.
REQ-030 When the wait counter reaches TIMEOUT, stall_err SHALL set and hold until reset; the packet SHALL stay presented and not be dropped.
REQ-031 The wait counter SHALL saturate at TIMEOUT.

Reset
REQ-032 On reset, all FIFOs SHALL empty.
REQ-033 On reset, state SHALL go to IDLE and last_grant SHALL become N_REQ-1, so requester 0 has first priority.
REQ-034 On reset, port_pndng, port_data, grant_id, pkt_cnt, stall_err and the wait counter SHALL clear to 0.
REQ-035 Reset asserted mid-BUSY SHALL discard the presented packet and all buffered packets; no partial state SHALL survive.

Verification
REQ-036 Single packet: write 0xA5A5_0001 on requester 2 while IDLE, router pops on the first pndng cycle -> pndng one cycle after the write edge, data 0xA5A5_0001, grant_id=2, pkt_cnt=1, then IDLE.
REQ-037 Round-robin: all 4 requesters each hold 2 packets, port_pop held 1 -> grant order 0,1,2,3,0,1,2,3 with pndng continuously 1, pkt_cnt=8.
REQ-038 Backpressure: fill requester 1 with 4 packets, no pop -> req_ready[1]=0; a 5th offer is refused; the presented data stays stable.
REQ-039 Timeout: BUSY with no pop for 64 cycles -> stall_err=1 and data still presented; a later pop is accepted normally and stall_err stays 1.
REQ-040 Reset mid-operation: reset while BUSY with 3 packets buffered -> the next cycle has pndng=0, pkt_cnt=0, all req_ready=1, and the first grant after reset goes to requester 0.
REQ-041 Spurious pop: port_pop=1 while IDLE -> pkt_cnt unchanged, state IDLE.
